// File: rtl/apb_master_ctrl_if.sv
// Processor request and dual APB bus bundle for apb_master_ctrl.
// master = controller side, slave = processor/bus environment side.
interface apb_master_ctrl_if;
    logic       start;
    logic       p_write;
    logic [1:0] p_sel;
    logic [7:0] p_addr;
    logic [7:0] p_wdata;
    logic [7:0] p_wait_cycles;
    logic [7:0] p_rdata;
    logic       stable;
    logic       busy;
    logic       error;
    logic       apb_write;
    logic [7:0] apb_addr;
    logic [7:0] apb_wdata;
    logic [7:0] apb_wait_cycles;
    logic [1:0] apb1_sel;
    logic       apb1_enable;
    logic       apb1_ready;
    logic [7:0] apb1_rdata;
    logic [1:0] apb2_sel;
    logic       apb2_enable;
    logic       apb2_ready;
    logic [7:0] apb2_rdata;

    modport master (
        input  start, p_write, p_sel, p_addr, p_wdata, p_wait_cycles,
        input  apb1_ready, apb1_rdata, apb2_ready, apb2_rdata,
        output p_rdata, stable, busy, error,
        output apb_write, apb_addr, apb_wdata, apb_wait_cycles,
        output apb1_sel, apb1_enable, apb2_sel, apb2_enable
    );

    modport slave (
        output start, p_write, p_sel, p_addr, p_wdata, p_wait_cycles,
        output apb1_ready, apb1_rdata, apb2_ready, apb2_rdata,
        input  p_rdata, stable, busy, error,
        input  apb_write, apb_addr, apb_wdata, apb_wait_cycles,
        input  apb1_sel, apb1_enable, apb2_sel, apb2_enable
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master controller: routes single processor requests to one of two
// APB buses with setup/access sequencing and an access-phase timeout.
module apb_master_ctrl #(
    parameter logic [1:0] ID1     = 2'b01,
    parameter logic [1:0] ID2     = 2'b10,
    parameter int         TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    apb_master_ctrl_if.master  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t     st_q, st_d;
    logic       wr_q, wr_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic       tgt1, tgt2, act, rdy;
    logic [7:0] rbus;

    // bus 1 wins if both IDs are equal
    assign tgt1 = (sel_q == ID1);
    assign tgt2 = !tgt1 && (sel_q == ID2);
    assign rdy  = tgt1 ? bus.apb1_ready : bus.apb2_ready;
    assign rbus = tgt1 ? bus.apb1_rdata : bus.apb2_rdata;
    assign act  = (st_q == SETUP) || (st_q == ACCESS);

    // state and transfer latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= IDLE;
            wr_q    <= 1'b0;
            sel_q   <= 2'b00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wait_q  <= 8'h00;
            rdata_q <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // next-state, latch updates, timeout tracking
    always_comb begin
        st_d    = st_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (st_q)
            IDLE: begin
                if (bus.start) begin
                    wr_d    = bus.p_write;
                    sel_d   = bus.p_sel;
                    addr_d  = bus.p_addr;
                    wdata_d = bus.p_wdata;
                    wait_d  = bus.p_wait_cycles;
                    err_d   = 1'b0;
                    if (bus.p_sel == ID1 || bus.p_sel == ID2) begin
                        st_d = SETUP;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 8'h00;
                        st_d    = DONE;
                    end
                end
            end
            SETUP: begin
                cnt_d = 8'h00;
                st_d  = ACCESS;
            end
            ACCESS: begin
                if (rdy) begin
                    if (!wr_q) rdata_d = rbus;
                    st_d = DONE;
                end else if (cnt_q == TLAST) begin
                    err_d = 1'b1;
                    if (!wr_q) rdata_d = 8'h00;
                    st_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // bus and processor outputs decoded from state and latches
    always_comb begin
        bus.p_rdata         = rdata_q;
        bus.error           = err_q;
        bus.stable          = (st_q == DONE);
        bus.busy            = (st_q != IDLE);
        bus.apb_write       = wr_q;
        bus.apb_addr        = addr_q;
        bus.apb_wdata       = wdata_q;
        bus.apb_wait_cycles = wait_q;
        bus.apb1_sel        = (act && tgt1) ? sel_q : 2'b00;
        bus.apb2_sel        = (act && tgt2) ? sel_q : 2'b00;
        bus.apb1_enable     = (st_q == ACCESS) && tgt1;
        bus.apb2_enable     = (st_q == ACCESS) && tgt2;
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: default instance plus a
// TIMEOUT=4 instance for timeout boundary cases.
module tb_apb_master_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    apb_master_ctrl_if bi ();
    apb_master_ctrl_if ti ();

    apb_master_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi)
    );

    apb_master_ctrl #(.TIMEOUT(4)) dut_t (
        .clk   (clk),
        .reset (reset),
        .bus   (ti)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        bi.start = 0; bi.p_write = 0; bi.p_sel = 0; bi.p_addr = 0;
        bi.p_wdata = 0; bi.p_wait_cycles = 0;
        bi.apb1_ready = 0; bi.apb1_rdata = 0;
        bi.apb2_ready = 0; bi.apb2_rdata = 0;
        ti.start = 0; ti.p_write = 0; ti.p_sel = 0; ti.p_addr = 0;
        ti.p_wdata = 0; ti.p_wait_cycles = 0;
        ti.apb1_ready = 0; ti.apb1_rdata = 0;
        ti.apb2_ready = 0; ti.apb2_rdata = 0;
        #1;
        chk("rst_rdata", bi.p_rdata, 8'h00);
        chk("rst_stable", bi.stable, 0);
        chk("rst_busy", bi.busy, 0);
        chk("rst_error", bi.error, 0);
        chk("rst_sel1", bi.apb1_sel, 0);
        chk("rst_sel2", bi.apb2_sel, 0);
        chk("rst_en1", bi.apb1_enable, 0);
        chk("rst_en2", bi.apb2_enable, 0);
        chk("rst_write", bi.apb_write, 0);
        chk("rst_addr", bi.apb_addr, 0);
        tick(); tick();
        reset = 1'b1;

        // write to bus 1, zero wait
        bi.p_write = 1; bi.p_sel = 2'b01; bi.p_addr = 8'h10;
        bi.p_wdata = 8'hA5; bi.p_wait_cycles = 8'h03;
        bi.apb1_ready = 1; bi.start = 1;
        tick();
        chk("t1_setup_sel1", bi.apb1_sel, 2'b01);
        chk("t1_setup_en1", bi.apb1_enable, 0);
        chk("t1_setup_sel2", bi.apb2_sel, 0);
        chk("t1_setup_busy", bi.busy, 1);
        chk("t1_setup_stable", bi.stable, 0);
        chk("t1_setup_wait", bi.apb_wait_cycles, 8'h03);
        bi.start = 0;
        tick();
        chk("t1_acc_en1", bi.apb1_enable, 1);
        chk("t1_acc_addr", bi.apb_addr, 8'h10);
        chk("t1_acc_wdata", bi.apb_wdata, 8'hA5);
        chk("t1_acc_write", bi.apb_write, 1);
        chk("t1_acc_sel2", bi.apb2_sel, 0);
        chk("t1_acc_stable", bi.stable, 0);
        tick();
        chk("t1_done_stable", bi.stable, 1);
        chk("t1_done_error", bi.error, 0);
        chk("t1_done_sel1", bi.apb1_sel, 0);
        chk("t1_done_en1", bi.apb1_enable, 0);
        tick();
        chk("t1_idle_stable", bi.stable, 0);
        chk("t1_idle_busy", bi.busy, 0);

        // read on bus 2 with 4 wait cycles; bus 1 ready ignored
        bi.p_write = 0; bi.p_sel = 2'b10; bi.p_addr = 8'h20;
        bi.apb2_ready = 0; bi.apb2_rdata = 8'h3C; bi.start = 1;
        tick();
        chk("t2_setup_sel2", bi.apb2_sel, 2'b10);
        chk("t2_setup_sel1", bi.apb1_sel, 0);
        bi.start = 0;
        tick();
        chk("t2_acc_en2", bi.apb2_enable, 1);
        chk("t2_acc_en1", bi.apb1_enable, 0);
        repeat (3) tick();
        chk("t2_wait_stable", bi.stable, 0);
        chk("t2_wait_en2", bi.apb2_enable, 1);
        tick();
        chk("t2_wait4_stable", bi.stable, 0);
        bi.apb2_ready = 1;
        tick();
        chk("t2_done_stable", bi.stable, 1);
        chk("t2_done_rdata", bi.p_rdata, 8'h3C);
        chk("t2_done_error", bi.error, 0);
        chk("t2_done_sel1", bi.apb1_sel, 0);
        bi.apb2_ready = 0;
        tick();

        // TIMEOUT=4: ready on the last allowed cycle succeeds
        ti.p_write = 0; ti.p_sel = 2'b01; ti.apb1_rdata = 8'h5A;
        ti.apb1_ready = 0; ti.start = 1;
        tick();
        chk("t3a_setup_sel1", ti.apb1_sel, 2'b01);
        ti.start = 0;
        repeat (4) tick();
        chk("t3a_acc_stable", ti.stable, 0);
        chk("t3a_acc_en1", ti.apb1_enable, 1);
        ti.apb1_ready = 1;
        tick();
        chk("t3a_done_stable", ti.stable, 1);
        chk("t3a_done_error", ti.error, 0);
        chk("t3a_done_rdata", ti.p_rdata, 8'h5A);
        ti.apb1_ready = 0;
        tick();

        // TIMEOUT=4: four ready-low cycles abort
        ti.start = 1;
        tick();
        ti.start = 0;
        repeat (4) tick();
        chk("t3b_acc_stable", ti.stable, 0);
        chk("t3b_acc_error", ti.error, 0);
        tick();
        chk("t3b_done_stable", ti.stable, 1);
        chk("t3b_done_error", ti.error, 1);
        chk("t3b_done_rdata", ti.p_rdata, 8'h00);
        chk("t3b_done_sel1", ti.apb1_sel, 0);
        chk("t3b_done_en1", ti.apb1_enable, 0);
        tick();
        chk("t3b_idle_stable", ti.stable, 0);
        chk("t3b_idle_busy", ti.busy, 0);
        chk("t3b_idle_error", ti.error, 1);

        // bad selects
        bi.p_sel = 2'b00; bi.start = 1;
        tick();
        chk("t4a_stable", bi.stable, 1);
        chk("t4a_error", bi.error, 1);
        chk("t4a_rdata", bi.p_rdata, 8'h00);
        chk("t4a_sel1", bi.apb1_sel, 0);
        chk("t4a_sel2", bi.apb2_sel, 0);
        chk("t4a_en1", bi.apb1_enable, 0);
        chk("t4a_en2", bi.apb2_enable, 0);
        bi.start = 0;
        tick();
        chk("t4a_idle_stable", bi.stable, 0);
        bi.p_sel = 2'b11; bi.start = 1;
        tick();
        chk("t4b_stable", bi.stable, 1);
        chk("t4b_error", bi.error, 1);
        chk("t4b_sel1", bi.apb1_sel, 0);
        chk("t4b_sel2", bi.apb2_sel, 0);
        bi.start = 0;
        tick();

        // valid read clears error
        bi.p_sel = 2'b01; bi.p_write = 0; bi.p_addr = 8'h44;
        bi.apb1_ready = 1; bi.apb1_rdata = 8'h77; bi.start = 1;
        tick();
        chk("t4c_setup_error", bi.error, 0);
        bi.start = 0;
        tick();
        tick();
        chk("t4c_done_stable", bi.stable, 1);
        chk("t4c_done_rdata", bi.p_rdata, 8'h77);
        chk("t4c_done_error", bi.error, 0);
        tick();

        // reset mid-ACCESS
        bi.apb1_ready = 0; bi.p_write = 1; bi.p_addr = 8'h55;
        bi.p_wdata = 8'h66; bi.start = 1;
        tick();
        bi.start = 0;
        tick();
        chk("t5_acc_en1", bi.apb1_enable, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_sel1", bi.apb1_sel, 0);
        chk("t5_rst_en1", bi.apb1_enable, 0);
        chk("t5_rst_busy", bi.busy, 0);
        chk("t5_rst_rdata", bi.p_rdata, 8'h00);
        chk("t5_rst_addr", bi.apb_addr, 8'h00);
        chk("t5_rst_wdata", bi.apb_wdata, 8'h00);
        chk("t5_rst_write", bi.apb_write, 0);
        tick();
        reset = 1'b1;
        bi.apb1_ready = 1; bi.start = 1;
        tick();
        chk("t5_re_sel1", bi.apb1_sel, 2'b01);
        bi.start = 0;
        tick();
        chk("t5_re_addr", bi.apb_addr, 8'h55);
        tick();
        chk("t5_re_stable", bi.stable, 1);
        chk("t5_re_error", bi.error, 0);
        tick();

        // back-to-back writes with start held high
        bi.p_write = 1; bi.p_sel = 2'b01; bi.p_addr = 8'h10;
        bi.p_wdata = 8'h11; bi.start = 1;
        tick();
        chk("t6_s1_sel1", bi.apb1_sel, 2'b01);
        bi.p_addr = 8'h99; bi.p_wdata = 8'h22;
        tick();
        chk("t6_a1_addr", bi.apb_addr, 8'h10);
        chk("t6_a1_wdata", bi.apb_wdata, 8'h11);
        tick();
        chk("t6_d1_stable", bi.stable, 1);
        tick();
        chk("t6_idle_busy", bi.busy, 0);
        chk("t6_idle_stable", bi.stable, 0);
        chk("t6_idle_sel1", bi.apb1_sel, 0);
        tick();
        chk("t6_s2_sel1", bi.apb1_sel, 2'b01);
        chk("t6_s2_addr", bi.apb_addr, 8'h99);
        bi.start = 0;
        tick();
        chk("t6_a2_en1", bi.apb1_enable, 1);
        chk("t6_a2_wdata", bi.apb_wdata, 8'h22);
        tick();
        chk("t6_d2_stable", bi.stable, 1);
        tick();
        chk("t6_end_stable", bi.stable, 0);
        chk("t6_end_busy", bi.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
